board_shuffler: RTL and testbench
=================================

Name: board_shuffler

Overview:
- Generates a fresh randomised 4x4 board of 8 tile pairs and writes it into the tile RAM before a round starts.
- Sits directly upstream of the in-game FSM. It drives the same tile RAM write port (through the top-level mux) while the game is not in progress.
- Raises `ready` when the board is loaded; top level gates `inGameOn` on `ready`.
- Tile word format matches the game FSM:
  - [7:2] pair id
  - [1] flipped
  - [0] cursor

Parameters:
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset. A value of 0 is replaced by 16'h0001.
- NUM_TILES, 16, board size. Fixed; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new board; sampled only in IDLE; level or pulse is accepted, rising edge detected internally
- busy  output  1  high from the cycle after start is accepted until the last RAM write completes
- ready  output  1  level; board valid in RAM; cleared when a new start is accepted
- done  output  1  one-cycle pulse, coincident with ready rising
- we  output  1  tile RAM write enable
- addr  output  4  tile RAM address
- wdata  output  8  tile RAM write data

Behaviour:
- Reset (async): state=IDLE, we=0, addr=0, wdata=0, busy=0, ready=0, done=0, LFSR=LFSR_SEED (or 1 if LFSR_SEED is 0), id array cleared.
- LFSR:
  - 16-bit Galois, taps mask 16'hB400, shift right.
  - Advances every clock in every state, so the cycle on which the player presses start selects the permutation.
  - Never reaches 0.
- Internal array id[0..15], 3 bits each.
- IDLE:
  - On a start rising edge (start & ~start_prev): go to INIT, busy=1 next cycle, ready=0.
  - Otherwise hold all outputs.
- INIT, 1 cycle: id[k] = k>>1 for all k; i=15; go to SHUFFLE.
- SHUFFLE (Fisher-Yates with rejection):
  - Each cycle, r = LFSR[3:0].
  - If r <= i: swap id[i] and id[r]; i <= i-1. If i was 1, go to WRITE with w=0.
  - If r > i: retry next cycle; no state change.
  - No retry limit; expected total is about 40 cycles.
- WRITE, 16 cycles:
  - Per cycle: we=1, addr=w, wdata={3'b000, id[w], 1'b0, (w==0)}.
  - The cursor bit is set only on tile 0, matching the game FSM's initial currentTile=0.
  - w increments. After w=15 is written, go to DONE.
- DONE, 1 cycle: we=0, busy=0, ready=1, done=1; go to IDLE.
- we is high only in WRITE and is registered; addr/wdata are valid in the same cycle as we.
- start while busy is ignored, including any edge that occurs during busy.
- ready holds until the next accepted start or reset.
- Reset mid-operation: we drops immediately (async). The RAM may hold a partial board; ready=0, so the game cannot start.
- Total latency from accepted start edge to done: 1 (INIT) + 15+rejections (SHUFFLE) + 16 (WRITE) + 1 (DONE) cycles.
- Output invariant: every pair id 0..7 appears exactly twice; flipped bits are all 0; exactly one cursor bit is set, at address 0.

Decomposition:
- Shared package `tile_pkg` holds:
  - TILE_ID_MSB=7, TILE_ID_LSB=2, TILE_FLIP_BIT=1, TILE_CURSOR_BIT=0
  - NUM_TILES=16, NUM_PAIRS=8
  - the shuffler state encoding (IDLE, INIT, SHUFFLE, WRITE, DONE)
- The game FSM imports the same field constants.
- One sub-module: `lfsr16`, with ports clk, reset, seed param, q[15:0]. It is reused for future AI/hint randomness.

Test Plan:
- Reset, then start pulse at cycle 10, LFSR_SEED=16'hACE1 → exactly 16 consecutive we cycles, addr 0..15 in order. Each id 0..7 appears twice, wdata[1]=0 everywhere, wdata[0]=1 only at addr 0. done is a single pulse; ready=1 afterwards. The exact permutation matches a bench LFSR/Fisher-Yates model.
- Same seed, start delayed by 1 cycle → a permutation different from the previous run, and equal to the model's output for that start cycle.
- Start re-asserted at 3 cycles and again at 20 cycles after acceptance (during busy) → ignored; only one sequence of 16 writes and one done pulse.
- Reset asserted mid-WRITE (after 5 writes) → we=0 in the same cycle, busy=0, ready=0, no done. The next start produces a complete 16-write board.
- LFSR_SEED=0 → behaves as seed 1; the LFSR never outputs 0 over 70000 cycles, and a board completes normally.
- Start held high for 100 cycles after done → no second shuffle (edge detect); a new low-then-high transition starts a new board and clears ready on acceptance.

Source files
------------

// File: rtl/tile_pkg.sv
// tile_pkg: shared definitions for the tile RAM word layout and the board
// shuffler. The game FSM imports the same field constants, so the two
// agree on the word format.
//   Tile word: [7:2] pair id, [1] flipped, [0] cursor.
package tile_pkg;

    localparam int TILE_ID_MSB     = 7;
    localparam int TILE_ID_LSB     = 2;
    localparam int TILE_FLIP_BIT   = 1;
    localparam int TILE_CURSOR_BIT = 0;

    localparam int NUM_TILES = 16;
    localparam int NUM_PAIRS = 8;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHUFFLE,
        WRITE,
        DONE
    } shufState_t;

    // Builds a face-down tile word with the given pair id and cursor bit.
    function automatic logic [7:0] makeTile(input logic [2:0] pairId, input logic cursor);
        logic [7:0] tile;
        tile = '0;
        tile[TILE_ID_MSB:TILE_ID_LSB] = {3'b000, pairId};
        tile[TILE_FLIP_BIT]           = 1'b0;
        tile[TILE_CURSOR_BIT]         = cursor;
        return tile;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, shift right, taps 16'hB400.
// Advances on every clock. A zero seed is replaced by 1 so the register
// can never lock up at zero.
//   clk   in   clock, rising edge
//   reset in   asynchronous, active-high; loads the seed
//   q     out  current LFSR value
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);
    import tile_pkg::*;

    localparam logic [15:0] START = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= START;
        end else begin
            q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/board_shuffler.sv
// board_shuffler: builds a random 4x4 board of 8 tile pairs (Fisher-Yates
// with rejection sampling on the LFSR low nibble) and writes it into the
// tile RAM, then raises ready.
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high
//   start  in   new-board request, rising edge accepted only in IDLE
//   busy   out  high from the cycle after acceptance until the last write
//   ready  out  board valid in RAM; cleared when a new start is accepted
//   done   out  one-cycle pulse as ready rises
//   we     out  tile RAM write enable
//   addr   out  tile RAM address
//   wdata  out  tile RAM write data
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a start rising edge; outputs held
// INIT    | id[k] = k>>1, i = 15
// SHUFFLE | r = lfsr[3:0]; swap id[i]/id[r] and step i when r <= i
// WRITE   | one tile per cycle, addr 0..15, cursor only on tile 0
// DONE    | drop busy, raise ready, pulse done
module board_shuffler #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          NUM_TILES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       ready,
    output logic       done,
    output logic       we,
    output logic [3:0] addr,
    output logic [7:0] wdata
);
    import tile_pkg::*;

    shufState_t  state;
    logic [15:0] lfsrQ;
    logic        startPrev;
    logic [2:0]  ids [NUM_TILES];
    logic [3:0]  idx;
    logic [3:0]  wIdx;
    logic [3:0]  r;

    lfsr16 #(.SEED(LFSR_SEED)) uLfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsrQ)
    );

    assign r = lfsrQ[3:0];

    // Upper LFSR bits are reserved for future hint/AI randomness.
    logic unusedLfsrHigh;
    assign unusedLfsrHigh = ^lfsrQ[15:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            startPrev <= 1'b0;
            idx       <= '0;
            wIdx      <= '0;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            done      <= 1'b0;
            for (int k = 0; k < NUM_TILES; k++) begin
                ids[k] <= '0;
            end
        end else begin
            // Sampled every cycle, so an edge seen while busy is consumed
            // and cannot trigger a second board later.
            startPrev <= start;
            we        <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !startPrev) begin
                        state <= INIT;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                    end
                end

                INIT: begin
                    for (int k = 0; k < NUM_TILES; k++) begin
                        ids[k] <= 3'(k >> 1);
                    end
                    idx   <= 4'(NUM_TILES - 1);
                    state <= SHUFFLE;
                end

                SHUFFLE: begin
                    // Rejecting r > i keeps the permutation unbiased.
                    if (r <= idx) begin
                        ids[idx] <= ids[r];
                        ids[r]   <= ids[idx];
                        idx      <= idx - 4'd1;
                        if (idx == 4'd1) begin
                            state <= WRITE;
                            wIdx  <= '0;
                        end
                    end
                end

                WRITE: begin
                    we    <= 1'b1;
                    addr  <= wIdx;
                    wdata <= makeTile(ids[wIdx], wIdx == 4'd0);
                    wIdx  <= wIdx + 4'd1;
                    if (wIdx == 4'(NUM_TILES - 1)) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_shuffler.sv
module tb_board_shuffler;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       busy, ready, done, we;
    logic [3:0] addr;
    logic [7:0] wdata;

    logic       rst0, start0;
    logic       busy0, ready0, done0, we0;
    logic [3:0] addr0;
    logic [7:0] wdata0;

    int vectors = 0;
    int miscompares = 0;
    int cyc, cyc0;

    int           wCnt, doneCnt;
    bit           orderBad, gapBad, doneBad, timedOut;
    logic [127:0] obs, board1;

    always #5 clk = ~clk;

    board_shuffler #(.LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .ready(ready),
        .done(done), .we(we), .addr(addr), .wdata(wdata)
    );

    board_shuffler #(.LFSR_SEED(16'h0000)) dutZero (
        .clk(clk), .reset(rst0), .start(start0), .busy(busy0), .ready(ready0),
        .done(done0), .we(we0), .addr(addr0), .wdata(wdata0)
    );

    always @(posedge clk or posedge reset) if (reset) cyc <= 0; else cyc <= cyc + 1;
    always @(posedge clk or posedge rst0)  if (rst0)  cyc0 <= 0; else cyc0 <= cyc0 + 1;

    // ---------------- reference model ----------------
    function automatic logic [15:0] lstep(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Board produced when start is raised during cycle s after reset release:
    // edge accepted at the next clock, one INIT cycle, so the first shuffle
    // draw uses the LFSR value s+2 steps after the seed.
    function automatic logic [127:0] model_board(input logic [15:0] seed, input int s);
        logic [15:0]  l;
        int           ids [16];
        int           i, r, t;
        logic [127:0] b;
        l = (seed == 16'h0000) ? 16'h0001 : seed;
        for (int k = 0; k < s + 2; k++) l = lstep(l);
        for (int k = 0; k < 16; k++) ids[k] = k / 2;
        i = 15;
        while (i >= 1) begin
            r = int'(l[3:0]);
            if (r <= i) begin
                t = ids[i]; ids[i] = ids[r]; ids[r] = t;
                i--;
            end
            l = lstep(l);
        end
        b = '0;
        for (int k = 0; k < 16; k++) b[8*k +: 8] = 8'((ids[k] << 2) | ((k == 0) ? 1 : 0));
        return b;
    endfunction

    // ---------------- stimulus / observation ----------------
    task automatic wait_cyc(input int s);
        while (cyc < s) @(negedge clk);
    endtask

    task automatic launch(output int s);
        s = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input int tail, input int budget);
        int  post;
        bit  seenDone, lastWe;
        wCnt = 0; doneCnt = 0; orderBad = 0; gapBad = 0; doneBad = 0;
        timedOut = 0; obs = '0; post = 0; seenDone = 0; lastWe = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (we) begin
                if (wCnt > 0 && !lastWe) gapBad = 1;
                if (wCnt < 16) begin
                    obs[8*wCnt +: 8] = wdata;
                    if (addr !== 4'(wCnt)) orderBad = 1;
                end
                wCnt++;
            end
            lastWe = we;
            if (done) begin
                doneCnt++;
                seenDone = 1;
                if (!ready || we || busy) doneBad = 1;
            end
            if (seenDone) begin
                post++;
                if (post > tail) break;
            end
        end
        if (!seenDone) timedOut = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        vectors++; if (we !== 1'b0)    begin miscompares++; $display("FAIL reset_we: got %0b expected 0", we); end
        vectors++; if (addr !== 4'h0)  begin miscompares++; $display("FAIL reset_addr: got %0h expected 0", addr); end
        vectors++; if (wdata !== 8'h0) begin miscompares++; $display("FAIL reset_wdata: got %0h expected 0", wdata); end
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %0b expected 0", ready); end
        vectors++; if (done !== 1'b0)  begin miscompares++; $display("FAIL reset_done: got %0b expected 0", done); end
    endtask

    task automatic test_first_board();
        int           cnt [8];
        bit           pairsOk, flipAny;
        logic [15:0]  curMask;
        logic [7:0]   t;
        logic [127:0] exp;
        @(negedge clk); reset = 1'b0;
        wait_cyc(10);
        start = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b1 || ready !== 1'b0) begin miscompares++; $display("FAIL first_accept: busy/ready %0b%0b expected 10", busy, ready); end
        start = 1'b0;
        collect(3, 600);
        exp = model_board(16'hACE1, 10);
        vectors++; if (timedOut)    begin miscompares++; $display("FAIL first_timeout: no done within budget"); end
        vectors++; if (wCnt !== 16) begin miscompares++; $display("FAIL first_wcount: got %0d expected 16", wCnt); end
        vectors++; if (orderBad || gapBad) begin miscompares++; $display("FAIL first_addr_order: order %0b gap %0b expected 0 0", orderBad, gapBad); end
        vectors++; if (doneCnt !== 1 || doneBad) begin miscompares++; $display("FAIL first_done: pulses %0d bad %0b expected 1 0", doneCnt, doneBad); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL first_ready: got %0b expected 1", ready); end
        vectors++; if (obs !== exp) begin miscompares++; $display("FAIL first_board: got %032h expected %032h", obs, exp); end
        pairsOk = 1; flipAny = 0; curMask = '0;
        for (int p = 0; p < 8; p++) cnt[p] = 0;
        for (int a = 0; a < 16; a++) begin
            t = obs[8*a +: 8];
            if (t[7:5] == 3'b000) cnt[t[4:2]]++; else pairsOk = 0;
            flipAny |= t[1];
            curMask[a] = t[0];
        end
        for (int p = 0; p < 8; p++) if (cnt[p] != 2) pairsOk = 0;
        vectors++; if (!pairsOk)  begin miscompares++; $display("FAIL first_pairs: ids not each twice, got %032h", obs); end
        vectors++; if (flipAny)   begin miscompares++; $display("FAIL first_flip: got 1 expected 0"); end
        vectors++; if (curMask !== 16'h0001) begin miscompares++; $display("FAIL first_cursor: got %04h expected 0001", curMask); end
        board1 = obs;
    endtask

    task automatic test_delayed_start();
        int           s;
        logic [127:0] exp;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        wait_cyc(11);
        launch(s);
        collect(3, 600);
        exp = model_board(16'hACE1, 11);
        vectors++; if (wCnt !== 16 || timedOut) begin miscompares++; $display("FAIL delayed_wcount: got %0d expected 16", wCnt); end
        vectors++; if (obs !== exp) begin miscompares++; $display("FAIL delayed_board: got %032h expected %032h", obs, exp); end
        vectors++; if (obs === board1) begin miscompares++; $display("FAIL delayed_differs: got %032h expected a different board", obs); end
    endtask

    task automatic test_ignore_busy();
        int           s;
        logic [127:0] exp;
        wait_cyc(cyc + 2);
        s = cyc;
        fork
            collect(60, 700);
            begin
                start = 1'b1; @(negedge clk); start = 1'b0;
                repeat (3)  @(negedge clk);
                start = 1'b1; @(negedge clk); start = 1'b0;
                repeat (15) @(negedge clk);
                start = 1'b1; @(negedge clk); start = 1'b0;
            end
        join
        exp = model_board(16'hACE1, s);
        vectors++; if (wCnt !== 16 || timedOut) begin miscompares++; $display("FAIL busy_wcount: got %0d expected 16", wCnt); end
        vectors++; if (doneCnt !== 1) begin miscompares++; $display("FAIL busy_done: got %0d pulses expected 1", doneCnt); end
        vectors++; if (obs !== exp) begin miscompares++; $display("FAIL busy_board: got %032h expected %032h", obs, exp); end
        vectors++; if (busy !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL busy_idle: busy/ready %0b%0b expected 01", busy, ready); end
    endtask

    task automatic test_reset_mid_write();
        int           s, n;
        bit           doneSeen;
        logic [127:0] exp;
        launch(s);
        n = 0;
        for (int c = 0; c < 400 && n < 5; c++) begin
            @(negedge clk);
            if (we) n++;
        end
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL midrst_reach: got %0d writes expected 5", n); end
        reset = 1'b1;
        #1;
        vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL midrst_we: got %0b expected 0", we); end
        vectors++; if (busy !== 1'b0 || ready !== 1'b0) begin miscompares++; $display("FAIL midrst_flags: busy/ready %0b%0b expected 00", busy, ready); end
        doneSeen = 0;
        repeat (3) begin @(negedge clk); if (done || we) doneSeen = 1; end
        vectors++; if (doneSeen) begin miscompares++; $display("FAIL midrst_done: got activity expected none"); end
        reset = 1'b0;
        wait_cyc(5);
        launch(s);
        collect(3, 600);
        exp = model_board(16'hACE1, s);
        vectors++; if (wCnt !== 16 || timedOut || orderBad) begin miscompares++; $display("FAIL midrst_rerun: got %0d writes expected 16", wCnt); end
        vectors++; if (obs !== exp) begin miscompares++; $display("FAIL midrst_board: got %032h expected %032h", obs, exp); end
    endtask

    task automatic test_hold_start();
        int           s, s2;
        logic [127:0] exp;
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        collect(100, 800);
        exp = model_board(16'hACE1, s);
        vectors++; if (wCnt !== 16 || doneCnt !== 1 || timedOut) begin miscompares++; $display("FAIL hold_single: got %0d writes %0d dones expected 16 1", wCnt, doneCnt); end
        vectors++; if (obs !== exp) begin miscompares++; $display("FAIL hold_board: got %032h expected %032h", obs, exp); end
        vectors++; if (busy !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL hold_idle: busy/ready %0b%0b expected 01", busy, ready); end
        start = 1'b0;
        @(negedge clk);
        s2 = cyc;
        start = 1'b1;
        @(negedge clk);
        vectors++; if (ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL hold_reaccept: busy/ready %0b%0b expected 10", busy, ready); end
        start = 1'b0;
        collect(3, 600);
        exp = model_board(16'hACE1, s2);
        vectors++; if (obs !== exp || wCnt !== 16) begin miscompares++; $display("FAIL hold_board2: got %032h expected %032h", obs, exp); end
    endtask

    task automatic test_random();
        int           s;
        logic [127:0] exp;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(1, 25)) @(negedge clk);
            launch(s);
            collect(2, 600);
            exp = model_board(16'hACE1, s);
            vectors++; if (wCnt !== 16 || timedOut || orderBad || gapBad) begin miscompares++; $display("FAIL rand%0d_writes: got %0d expected 16", k, wCnt); end
            vectors++; if (obs !== exp) begin miscompares++; $display("FAIL rand%0d_board: got %032h expected %032h", k, obs, exp); end
        end
    endtask

    task automatic test_seed_zero();
        logic [15:0]  mq;
        int           walkBad, zeroHits, s0, n;
        bit           bad, seenDone;
        logic [127:0] b0, exp;
        @(negedge clk); rst0 = 1'b0;
        mq = 16'h0001; walkBad = 0; zeroHits = 0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            mq = lstep(mq);
            if (dutZero.uLfsr.q !== mq) walkBad++;
            if (dutZero.uLfsr.q === 16'h0000) zeroHits++;
        end
        vectors++; if (walkBad !== 0)  begin miscompares++; $display("FAIL seed0_walk: got %0d deviations expected 0", walkBad); end
        vectors++; if (zeroHits !== 0) begin miscompares++; $display("FAIL seed0_zero: got %0d zero states expected 0", zeroHits); end
        s0 = cyc0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0; bad = 0; seenDone = 0; b0 = '0;
        for (int c = 0; c < 600 && !seenDone; c++) begin
            @(negedge clk);
            if (we0) begin
                if (n < 16) begin b0[8*n +: 8] = wdata0; if (addr0 !== 4'(n)) bad = 1; end
                n++;
            end
            if (done0) begin seenDone = 1; if (!ready0 || busy0) bad = 1; end
        end
        exp = model_board(16'h0000, s0);
        vectors++; if (n !== 16 || !seenDone || bad) begin miscompares++; $display("FAIL seed0_writes: got %0d done %0b expected 16 1", n, seenDone); end
        vectors++; if (b0 !== exp) begin miscompares++; $display("FAIL seed0_board: got %032h expected %032h", b0, exp); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        rst0 = 1'b1;  start0 = 1'b0;
        test_reset();
        test_first_board();
        test_delayed_start();
        test_ignore_busy();
        test_reset_mid_write();
        test_hold_start();
        test_random();
        test_seed_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
